// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Purpose  : Gated rising-edge counter with duty and signal-present reporting
//            for a looped-back square wave.
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CW          = 32,
  parameter int HW          = 26
) (
  input  logic          M_CLOCK,
  input  logic          RESET,
  input  logic          enable,
  input  logic          meas_in,
  output logic [CW-1:0] freq_count,
  output logic [HW-1:0] high_count,
  output logic          result_valid,
  output logic          overflow,
  output logic          no_signal,
  output logic          stuck_level
);

  localparam logic [HW-1:0] C_GATE_LAST = HW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] C_EDGE_MAX  = {CW{1'b1}};

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [HW-1:0] r_gate;
  logic [CW-1:0] r_edge_acc;
  logic [HW-1:0] r_high_acc;
  logic          r_ovf_acc;

  logic          w_rise;
  logic          w_terminal;
  logic          w_edge_at_max;
  logic [CW-1:0] w_edge_next;
  logic [HW-1:0] w_high_next;
  logic          w_ovf_next;

  assign w_rise        = r_sync2 & ~r_prev;
  assign w_terminal    = enable && (r_gate == C_GATE_LAST);
  assign w_edge_at_max = (r_edge_acc == C_EDGE_MAX);
  assign w_edge_next   = (w_rise && !w_edge_at_max) ? r_edge_acc + CW'(1) : r_edge_acc;
  assign w_ovf_next    = r_ovf_acc | (w_rise & w_edge_at_max);
  assign w_high_next   = r_high_acc + HW'(r_sync2);

  // Synchroniser resets high so that releasing reset never looks like a rise.
  always_ff @(posedge M_CLOCK) begin
    if (RESET) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= meas_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge M_CLOCK) begin
    if (RESET || !enable || w_terminal) begin
      r_gate     <= '0;
      r_edge_acc <= '0;
      r_high_acc <= '0;
      r_ovf_acc  <= 1'b0;
    end else begin
      r_gate     <= r_gate + HW'(1);
      r_edge_acc <= w_edge_next;
      r_high_acc <= w_high_next;
      r_ovf_acc  <= w_ovf_next;
    end
  end

  // Results include the terminal cycle's own contribution via the *_next terms.
  always_ff @(posedge M_CLOCK) begin
    if (RESET) begin
      freq_count   <= '0;
      high_count   <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      no_signal    <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      result_valid <= w_terminal;
      if (w_terminal) begin
        freq_count  <= w_edge_next;
        high_count  <= w_high_next;
        overflow    <= w_ovf_next;
        no_signal   <= (w_edge_next == '0);
        stuck_level <= r_sync2;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter
// Purpose  : Self-checking bench for freq_meter against a window-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int G    = 100;
  localparam int CWT  = 4;
  localparam int HWT  = 8;
  localparam int SATV = (1 << CWT) - 1;

  logic           M_CLOCK = 1'b0;
  logic           RESET   = 1'b1;
  logic           enable  = 1'b0;
  logic           meas_in = 1'b1;
  logic [CWT-1:0] freq_count;
  logic [HWT-1:0] high_count;
  logic           result_valid;
  logic           overflow;
  logic           no_signal;
  logic           stuck_level;

  freq_meter #(.GATE_CYCLES(G), .CW(CWT), .HW(HWT)) dut (
    .M_CLOCK     (M_CLOCK),
    .RESET       (RESET),
    .enable      (enable),
    .meas_in     (meas_in),
    .freq_count  (freq_count),
    .high_count  (high_count),
    .result_valid(result_valid),
    .overflow    (overflow),
    .no_signal   (no_signal),
    .stuck_level (stuck_level)
  );

  always #5 M_CLOCK = ~M_CLOCK;

  int errors = 0;
  int checks = 0;

  // lv[n] is the pin level as it enters the synchroniser at edge n
  bit lv [0:16383];
  int n     = 2;
  int since = 0;
  int e_freq = 0, e_high = 0;
  logic e_valid = 1'b0, e_ovf = 1'b0, e_nosig = 1'b0, e_stuck = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at edge %0d", tag, obs, exp, n);
    end
  endtask

  // The result of a window closing at edge n is the history of the synchronised
  // level (pin two edges earlier) over the last G edges.
  task automatic close_window();
    int r = 0;
    int h = 0;
    for (int k = n - G + 1; k <= n; k++) begin
      h += int'(lv[k-2]);
      if (lv[k-2] && !lv[k-3]) r++;
    end
    e_freq  = (r > SATV) ? SATV : r;
    e_ovf   = (r > SATV);
    e_nosig = (r == 0);
    e_stuck = lv[n-2];
    e_high  = h;
    e_valid = 1'b1;
  endtask

  task automatic tick(input logic p, input logic en, input logic rst);
    meas_in = p;
    enable  = en;
    RESET   = rst;
    @(posedge M_CLOCK);
    n++;
    lv[n] = p;
    e_valid = 1'b0;
    if (rst) begin
      lv[n] = 1'b1; lv[n-1] = 1'b1; lv[n-2] = 1'b1;
      since = 0;
      e_freq = 0; e_high = 0; e_ovf = 1'b0; e_nosig = 1'b0; e_stuck = 1'b0;
    end else if (!en) begin
      since = 0;
    end else if (since == G - 1) begin
      close_window();
      since = 0;
    end else begin
      since++;
    end
    @(negedge M_CLOCK);
    chk("valid",    32'(result_valid), 32'(e_valid));
    chk("freq",     32'(freq_count),   32'(e_freq));
    chk("high",     32'(high_count),   32'(e_high));
    chk("overflow", 32'(overflow),     32'(e_ovf));
    chk("nosig",    32'(no_signal),    32'(e_nosig));
    chk("stuck",    32'(stuck_level),  32'(e_stuck));
  endtask

  // Periodic pattern; once fully settled every valid must show the known figures.
  task automatic run_pat(input int hi, input int per, input int cycles,
                         input int cf, input int ch);
    for (int i = 0; i < cycles; i++) begin
      tick(((i % per) < hi), 1'b1, 1'b0);
      if (i >= 105 && result_valid === 1'b1) begin
        chk("const_freq", 32'(freq_count), 32'(cf));
        chk("const_high", 32'(high_count), 32'(ch));
      end
    end
  endtask

  initial begin
    int lvl, left, gap;
    for (int i = 0; i < 3; i++) lv[i] = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);

    run_pat(5, 10, 350, 10, 50);
    tick(1'b1, 1'b1, 1'b1);
    run_pat(1, 1, 250, 0, 100);
    run_pat(0, 1, 250, 0, 0);
    run_pat(2, 4, 250, SATV, 50);
    run_pat(5, 10, 250, 10, 50);
    run_pat(5, 20, 250, 5, 25);

    // Enable gap mid-window
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 60; i++) tick(((i % 10) < 5), 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) tick(((i % 10) < 5), 1'b0, 1'b0);
    for (int i = 0; i < 250; i++) tick(((i % 10) < 5), 1'b1, 1'b0);

    // Reset mid-window with the pin high
    for (int i = 0; i < 50; i++) tick(((i % 10) < 5), 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    chk("rst_freq",  32'(freq_count),   32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    for (int i = 0; i < 150; i++) tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 250; i++) tick(((i % 10) < 5), 1'b1, 1'b0);

    // Rise landing exactly on the terminal cycle belongs to the closing window
    tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 97; i++) tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    chk("term_valid", 32'(result_valid), 32'd1);
    chk("term_freq",  32'(freq_count),   32'd1);

    lvl = 0; left = 0; gap = 0;
    for (int i = 0; i < 4000 && n < 16000; i++) begin
      if (left == 0) begin
        lvl  = 1 - lvl;
        left = ($urandom_range(19, 0) == 0) ? int'($urandom_range(160, 60))
                                            : int'($urandom_range(12, 1));
      end
      if (gap > 0) gap--;
      else if ($urandom_range(299, 0) == 0) gap = $urandom_range(40, 1);
      tick(lvl[0], (gap == 0), ($urandom_range(1499, 0) == 0));
      left--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
